// File: rtl/stencil_2d_launcher.sv
// stencil_2d_launcher: call controller in front of the stencil_2d HLS component.
// Accepts host invocations, drives the component call interface (honouring busy),
// and collects returndata into an in-order response FIFO with stall backpressure.
// Optional feature macro: STENCIL_LAUNCH_LATENCY_EN adds rsp_latency_o, a
// free-running cycle counter and a call timestamp FIFO.
//
// state | meaning
// IDLE  | no call waiting; may accept a command
// ISSUE | k_start high, arguments held until the component takes the call
module stencil_2d_launcher #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int RSP_DEPTH       = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [63:0] cmd_orig_i,
    input  logic [63:0] cmd_sol_i,
    input  logic [63:0] cmd_filter_i,
    output logic        k_start_o,
    input  logic        k_busy_i,
    output logic [63:0] k_orig_o,
    output logic [63:0] k_sol_o,
    output logic [63:0] k_filter_o,
    input  logic        k_done_i,
    output logic        k_stall_o,
    input  logic [31:0] k_returndata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
`ifdef STENCIL_LAUNCH_LATENCY_EN
    output logic [31:0] rsp_latency_o,
`endif
    output logic [4:0]  inflight_o,
    output logic        err_spurious_o
);

    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam int RSP_CW = RSP_AW + 1;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t      state_q;
    logic        k_start_q;
    logic [63:0] k_orig_q, k_sol_q, k_filter_q;
    logic [4:0]  inflight_q, inflight_d;
    logic        err_q;

    logic [31:0]       rsp_mem_q [RSP_DEPTH];
    logic [RSP_AW-1:0] rsp_wr_q, rsp_rd_q;
    logic [RSP_CW-1:0] rsp_cnt_q, rsp_cnt_d;

    logic issue_pending;
    logic cmd_accept, call_accept, ret_accept, ret_valid;
    logic rsp_push, rsp_pop, rsp_full, rsp_empty;

    assign issue_pending = (state_q == ISSUE);
    // Ready depends only on registered state and reset, never on cmd_valid_i.
    assign cmd_ready_o   = !reset_i && !issue_pending &&
                           (({1'b0, inflight_q} + 6'(issue_pending)) < 6'(MAX_OUTSTANDING));
    assign cmd_accept    = cmd_valid_i && cmd_ready_o;
    assign call_accept   = k_start_q && !k_busy_i;

    // Stall comes from registered occupancy only; a same-cycle pop does not release it.
    assign rsp_full      = (rsp_cnt_q == RSP_CW'(RSP_DEPTH));
    assign rsp_empty     = (rsp_cnt_q == '0);
    assign ret_accept    = k_done_i && !rsp_full;
    assign ret_valid     = ret_accept && (inflight_q != '0);
    assign rsp_push      = ret_valid;
    assign rsp_pop       = !rsp_empty && rsp_ready_i;

    // Issue FSM: capture arguments on command accept, hold start until the call is taken.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            k_start_q  <= 1'b0;
            k_orig_q   <= '0;
            k_sol_q    <= '0;
            k_filter_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_accept) begin
                        state_q    <= ISSUE;
                        k_start_q  <= 1'b1;
                        k_orig_q   <= cmd_orig_i;
                        k_sol_q    <= cmd_sol_i;
                        k_filter_q <= cmd_filter_i;
                    end
                end
                ISSUE: begin
                    if (!k_busy_i) begin
                        state_q   <= IDLE;
                        k_start_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    k_start_q <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding-call count: call accepts add, non-spurious returns subtract.
    always_comb begin
        inflight_d = inflight_q;
        if (call_accept && !ret_valid) begin
            inflight_d = inflight_q + 5'd1;
        end else if (!call_accept && ret_valid) begin
            inflight_d = inflight_q - 5'd1;
        end
    end

    // Inflight register and sticky spurious-return flag.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (ret_accept && (inflight_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Response occupancy next-state; push and pop together cancel out.
    always_comb begin
        rsp_cnt_d = rsp_cnt_q;
        if (rsp_push && !rsp_pop) begin
            rsp_cnt_d = rsp_cnt_q + RSP_CW'(1);
        end else if (!rsp_push && rsp_pop) begin
            rsp_cnt_d = rsp_cnt_q - RSP_CW'(1);
        end
    end

    // Response FIFO pointers and occupancy; power-of-two depth wraps naturally.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (rsp_push) rsp_wr_q <= rsp_wr_q + RSP_AW'(1);
            if (rsp_pop)  rsp_rd_q <= rsp_rd_q + RSP_AW'(1);
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    // Response data storage; contents need no reset since empty masks the output.
    always_ff @(posedge clock_i) begin
        if (rsp_push) begin
            rsp_mem_q[rsp_wr_q] <= k_returndata_i;
        end
    end

`ifdef STENCIL_LAUNCH_LATENCY_EN
    localparam int TS_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]      cyc_q;
    logic [31:0]      ts_mem_q [MAX_OUTSTANDING];
    logic [TS_AW-1:0] ts_wr_q, ts_rd_q;
    logic [31:0]      lat_mem_q [RSP_DEPTH];

    // Free-running cycle counter, zero in the first cycle after reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) cyc_q <= '0;
        else         cyc_q <= cyc_q + 32'd1;
    end

    // Timestamp FIFO pointers; inflight bounds occupancy so no count is needed.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ts_wr_q <= '0;
            ts_rd_q <= '0;
        end else begin
            if (call_accept) begin
                ts_wr_q <= (ts_wr_q == TS_AW'(MAX_OUTSTANDING - 1)) ? '0 : ts_wr_q + TS_AW'(1);
            end
            if (ret_valid) begin
                ts_rd_q <= (ts_rd_q == TS_AW'(MAX_OUTSTANDING - 1)) ? '0 : ts_rd_q + TS_AW'(1);
            end
        end
    end

    // Stamp calls on accept; store elapsed cycles alongside each returned value.
    always_ff @(posedge clock_i) begin
        if (call_accept) ts_mem_q[ts_wr_q] <= cyc_q;
        if (rsp_push)    lat_mem_q[rsp_wr_q] <= cyc_q - ts_mem_q[ts_rd_q];
    end

    assign rsp_latency_o = rsp_empty ? '0 : lat_mem_q[rsp_rd_q];
`endif

    assign k_start_o      = k_start_q;
    assign k_orig_o       = k_orig_q;
    assign k_sol_o        = k_sol_q;
    assign k_filter_o     = k_filter_q;
    assign k_stall_o      = rsp_full;
    assign rsp_valid_o    = !rsp_empty;
    assign rsp_data_o     = rsp_empty ? '0 : rsp_mem_q[rsp_rd_q];
    assign inflight_o     = inflight_q;
    assign err_spurious_o = err_q;

endmodule

// File: tb/tb_stencil_2d_launcher.sv
// Testbench for stencil_2d_launcher: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based transaction model.
module tb_stencil_2d_launcher;

    localparam int MAXO = 4;
    localparam int RSPD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [63:0] cmd_orig, cmd_sol, cmd_filter;
    logic        k_start, k_busy;
    logic [63:0] k_orig, k_sol, k_filter;
    logic        k_done, k_stall;
    logic [31:0] k_returndata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_latency;
    logic [4:0]  inflight;
    logic        err_spurious;

    always #5 clk = ~clk;

    stencil_2d_launcher #(.MAX_OUTSTANDING(MAXO), .RSP_DEPTH(RSPD)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_orig_i     (cmd_orig),
        .cmd_sol_i      (cmd_sol),
        .cmd_filter_i   (cmd_filter),
        .k_start_o      (k_start),
        .k_busy_i       (k_busy),
        .k_orig_o       (k_orig),
        .k_sol_o        (k_sol),
        .k_filter_o     (k_filter),
        .k_done_i       (k_done),
        .k_stall_o      (k_stall),
        .k_returndata_i (k_returndata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
`ifdef STENCIL_LAUNCH_LATENCY_EN
        .rsp_latency_o  (rsp_latency),
`endif
        .inflight_o     (inflight),
        .err_spurious_o (err_spurious)
    );

`ifndef STENCIL_LAUNCH_LATENCY_EN
    assign rsp_latency = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: one pending issue, a count of calls owed a return,
    // their start stamps, and the queue of responses waiting for the host.
    bit          m_issuing;
    logic [63:0] m_orig, m_sol, m_filter;
    int          m_inflight;
    bit          m_err;
    int unsigned m_cyc;
    int unsigned m_stamp[$];
    logic [31:0] m_rsp[$];
    int unsigned m_lat[$];
    bit          ev_cmd, ev_call, ev_ret;

    function automatic bit m_cmd_ready();
        return !rst && !m_issuing && (m_inflight + int'(m_issuing)) < MAXO;
    endfunction

    task automatic m_reset();
        m_issuing = 0; m_orig = '0; m_sol = '0; m_filter = '0;
        m_inflight = 0; m_err = 0; m_cyc = 0;
        m_stamp.delete(); m_rsp.delete(); m_lat.delete();
    endtask

    task automatic compare_all();
        chk("cmd_ready", cmd_ready, m_cmd_ready());
        chk("k_start", k_start, m_issuing);
        if (m_issuing) begin
            chk("k_orig", k_orig, m_orig);
            chk("k_sol", k_sol, m_sol);
            chk("k_filter", k_filter, m_filter);
        end
        chk("k_stall", k_stall, m_rsp.size() == RSPD);
        chk("rsp_valid", rsp_valid, m_rsp.size() != 0);
        if (m_rsp.size() != 0) begin
            chk("rsp_data", rsp_data, m_rsp[0]);
`ifdef STENCIL_LAUNCH_LATENCY_EN
            chk("rsp_latency", rsp_latency, m_lat[0]);
`endif
        end else begin
            chk("rsp_data_empty", rsp_data, 0);
        end
        chk("inflight", inflight, m_inflight);
        chk("err_spurious", err_spurious, m_err);
    endtask

    // One clock: derive the handshakes from model state and inputs, clock, update, compare.
    task automatic step();
        bit stall, pop;
        stall   = (m_rsp.size() == RSPD);
        ev_cmd  = cmd_valid && m_cmd_ready();
        ev_call = m_issuing && !k_busy;
        ev_ret  = k_done && !stall;
        pop     = (m_rsp.size() != 0) && rsp_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_reset();
            ev_cmd = 0; ev_call = 0; ev_ret = 0;
        end else begin
            if (pop) begin
                void'(m_rsp.pop_front());
                void'(m_lat.pop_front());
            end
            if (ev_ret) begin
                if (m_inflight == 0) begin
                    m_err = 1;
                end else begin
                    m_rsp.push_back(k_returndata);
                    m_lat.push_back(m_cyc - m_stamp.pop_front());
                    m_inflight--;
                end
            end
            if (ev_call) begin
                m_inflight++;
                m_stamp.push_back(m_cyc);
                m_issuing = 0;
            end
            if (ev_cmd) begin
                m_issuing = 1;
                m_orig = cmd_orig; m_sol = cmd_sol; m_filter = cmd_filter;
            end
            m_cyc++;
        end
        compare_all();
    endtask

    task automatic send_cmd(input logic [63:0] o, input logic [63:0] s, input logic [63:0] f);
        cmd_valid = 1; cmd_orig = o; cmd_sol = s; cmd_filter = f;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ev_cmd) break;
        end
        chk("cmd_accept_seen", ev_cmd, 1);
        cmd_valid = 0;
    endtask

    task automatic do_return(input logic [31:0] d);
        k_done = 1; k_returndata = d;
        step();
        k_done = 0;
    endtask

    initial begin
        int kcnt, acc, d;
        rst = 1; cmd_valid = 0; cmd_orig = '0; cmd_sol = '0; cmd_filter = '0;
        k_busy = 0; k_done = 0; k_returndata = '0; rsp_ready = 0;
        m_reset();
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_k_start", k_start, 0);
        rst = 0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Single call with a return 10 cycles after call accept.
        send_cmd(64'h1000, 64'h2000, 64'h3000);
        chk("single_k_orig", k_orig, 64'h1000);
        step();
        chk("single_call_accept", ev_call, 1);
        chk("single_k_start_drop", k_start, 0);
        repeat (9) step();
        do_return(32'h2A);
        chk("single_rsp_data", rsp_data, 32'h2A);
        chk("single_inflight", inflight, 0);
`ifdef STENCIL_LAUNCH_LATENCY_EN
        chk("single_latency", rsp_latency, 10);
`endif
        rsp_ready = 1; step(); rsp_ready = 0;

        // Busy hold for 5 cycles during ISSUE.
        k_busy = 1;
        send_cmd(64'hAAAA_0001, 64'hBBBB_0002, 64'hCCCC_0003);
        kcnt = k_start ? 1 : 0;
        repeat (5) begin
            step();
            if (k_start) kcnt++;
            chk("busy_cmd_ready", cmd_ready, 0);
        end
        k_busy = 0;
        step();
        chk("busy_hold_cycles", kcnt, 6);
        do_return(32'h55);
        rsp_ready = 1; step(); rsp_ready = 0;

        // Outstanding limit: hold cmd_valid, only MAXO calls go out.
        cmd_valid = 1; acc = 0;
        for (int i = 0; i < 14; i++) begin
            cmd_orig = {$urandom, $urandom}; cmd_sol = {$urandom, $urandom};
            cmd_filter = {$urandom, $urandom};
            step();
            if (ev_cmd) acc++;
        end
        cmd_valid = 0;
        chk("limit_accepts", acc, MAXO);
        chk("limit_inflight", inflight, MAXO);
        chk("limit_cmd_ready", cmd_ready, 0);
        do_return(32'd1);
        chk("limit_reraise", cmd_ready, 1);
        send_cmd(64'h5, 64'h6, 64'h7);
        step();

        // Response full: data 2.. until four entries wait, 5th held by stall.
        d = 2;
        k_done = 1;
        for (int i = 0; i < 20 && m_rsp.size() < RSPD; i++) begin
            k_returndata = d;
            step();
            if (ev_ret) d++;
        end
        chk("full_k_stall", k_stall, 1);
        k_returndata = d;
        repeat (3) begin
            step();
            chk("full_no_accept", ev_ret, 0);
        end
        rsp_ready = 1;
        step();
        chk("full_pop_no_release", ev_ret, 0);
        rsp_ready = 0;
        step();
        chk("full_fifth_accept", ev_ret, 1);
        k_done = 0;
        rsp_ready = 1;
        for (int v = 2; v <= 5; v++) begin
            chk("drain_order", rsp_data, v);
            step();
        end
        rsp_ready = 0;
        chk("drain_empty", rsp_valid, 0);

        // Spurious return.
        chk("pre_spur_inflight", inflight, 0);
        do_return(32'hDEAD);
        chk("spur_err", err_spurious, 1);
        chk("spur_rsp_valid", rsp_valid, 0);
        chk("spur_inflight", inflight, 0);

        // Simultaneous call and return accept with inflight at 2.
        rst = 1; step(); rst = 0;
        send_cmd(64'h11, 64'h12, 64'h13); step();
        send_cmd(64'h21, 64'h22, 64'h23); step();
        send_cmd(64'h31, 64'h32, 64'h33);
        chk("simul_pre_inflight", inflight, 2);
        k_done = 1; k_returndata = 32'h77;
        step();
        k_done = 0;
        chk("simul_both", ev_call && ev_ret, 1);
        chk("simul_inflight", inflight, 2);

        // Randomized traffic.
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid    = ($urandom_range(0, 1) == 1);
            cmd_orig     = {$urandom, $urandom};
            cmd_sol      = {$urandom, $urandom};
            cmd_filter   = {$urandom, $urandom};
            k_busy       = ($urandom_range(0, 9) < 3);
            k_done       = (m_inflight > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0);
            k_returndata = $urandom;
            rsp_ready    = ($urandom_range(0, 9) < 4);
            step();
        end
        cmd_valid = 0; k_done = 0; k_busy = 0; rsp_ready = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
